// File: rtl/mesif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesif_pkg
// Purpose  : MESIF state, bus op and snoop result encodings plus the snoop
//            next-state/result function shared by the snoop-side and
//            processor-side line logic.
// Revision : 1.0
// ============================================================================
package mesif_pkg;

    localparam logic [2:0] c_ST_M = 3'd0;
    localparam logic [2:0] c_ST_E = 3'd1;
    localparam logic [2:0] c_ST_S = 3'd2;
    localparam logic [2:0] c_ST_I = 3'd3;
    localparam logic [2:0] c_ST_F = 3'd4;

    localparam logic [2:0] c_OP_READ  = 3'd1;
    localparam logic [2:0] c_OP_WRITE = 3'd2;
    localparam logic [2:0] c_OP_INV   = 3'd3;
    localparam logic [2:0] c_OP_RFO   = 3'd4;

    localparam logic [1:0] c_RES_HIT   = 2'd0;
    localparam logic [1:0] c_RES_HITM  = 2'd1;
    localparam logic [1:0] c_RES_NOHIT = 2'd3;

    typedef struct packed {
        logic [1:0] result;
        logic [2:0] next_state;
        logic       write;
        logic       err;
        logic       wb;
    } snoop_resp_t;

    function automatic snoop_resp_t snoop_next(input logic [2:0] op,
                                               input logic       hit,
                                               input logic [2:0] cur);
        snoop_resp_t r;
        r.result     = c_RES_NOHIT;
        r.next_state = cur;
        r.err        = 1'b0;
        r.wb         = 1'b0;
        case (op)
            c_OP_READ: if (hit) begin
                case (cur)
                    c_ST_M: begin r.result = c_RES_HITM; r.next_state = c_ST_S; r.wb = 1'b1; end
                    c_ST_E,
                    c_ST_F: begin r.result = c_RES_HIT;  r.next_state = c_ST_S; end
                    c_ST_S: r.result = c_RES_HIT;
                    default: r.err = 1'b1;
                endcase
            end
            c_OP_RFO: if (hit) begin
                case (cur)
                    c_ST_M: begin r.result = c_RES_HITM; r.next_state = c_ST_I; r.wb = 1'b1; end
                    c_ST_E,
                    c_ST_S,
                    c_ST_F: begin r.result = c_RES_HIT;  r.next_state = c_ST_I; end
                    default: r.err = 1'b1;
                endcase
            end
            c_OP_INV: if (hit) begin
                case (cur)
                    c_ST_S,
                    c_ST_F: begin r.result = c_RES_HIT; r.next_state = c_ST_I; end
                    c_ST_M,
                    c_ST_E: begin r.next_state = c_ST_I; r.err = 1'b1; end
                    default: r.err = 1'b1;
                endcase
            end
            c_OP_WRITE: if (hit) r.err = 1'b1;
            default:    r.err = 1'b1;
        endcase
        r.write = (r.next_state != cur);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/way_match.sv
`default_nettype none
// ============================================================================
// Module   : way_match
// Purpose  : Tag compare across all ways of a set with lowest-way priority.
// Revision : 1.0
// ============================================================================
module way_match
    import mesif_pkg::*;
#(
    parameter int TAG_BITS = 12,
    parameter int WAYS     = 8,
    parameter int WAY_BITS = 3
) (
    input  logic [TAG_BITS-1:0]      tag_i,
    input  logic [WAYS*TAG_BITS-1:0] tags_i,
    input  logic [WAYS*3-1:0]        states_i,
    output logic                     hit_o,
    output logic [WAY_BITS-1:0]      hit_way_o,
    output logic [2:0]               hit_state_o,
    output logic                     multi_hit_o
);

    logic [WAYS-1:0] w_match;

    for (genvar g = 0; g < WAYS; g++) begin : g_match
        assign w_match[g] = (tags_i[g*TAG_BITS +: TAG_BITS] == tag_i) &&
                            (states_i[g*3 +: 3] != c_ST_I);
    end

    // Scan from the top way down so the lowest matching way is the last writer.
    always_comb begin
        hit_o       = 1'b0;
        hit_way_o   = '0;
        hit_state_o = c_ST_I;
        multi_hit_o = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                multi_hit_o = multi_hit_o | hit_o;
                hit_o       = 1'b1;
                hit_way_o   = WAY_BITS'(w);
                hit_state_o = states_i[w*3 +: 3];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : snoop_responder
// Purpose  : Bus-side MESIF snoop responder: set lookup, snoop result,
//            state write-back and writeback request for modified lines.
// Revision : 1.0
// ============================================================================
module snoop_responder
    import mesif_pkg::*;
#(
    parameter int TAG_BITS   = 12,
    parameter int INDEX_BITS = 14,
    parameter int WAYS       = 8,
    parameter int WAY_BITS   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     snoop_valid,
    output logic                     snoop_ready,
    input  logic [2:0]               snoop_op,
    input  logic [TAG_BITS-1:0]      snoop_tag,
    input  logic [INDEX_BITS-1:0]    snoop_index,
    output logic                     arr_rd_en,
    output logic [INDEX_BITS-1:0]    arr_index,
    input  logic [WAYS*TAG_BITS-1:0] arr_tags,
    input  logic [WAYS*3-1:0]        arr_states,
    output logic                     arr_wr_en,
    output logic [WAY_BITS-1:0]      arr_wr_way,
    output logic [2:0]               arr_wr_state,
    output logic                     snoop_result_valid,
    output logic [1:0]               snoop_result,
    output logic                     wb_req,
    output logic [TAG_BITS-1:0]      wb_tag,
    output logic [INDEX_BITS-1:0]    wb_index,
    output logic [WAY_BITS-1:0]      wb_way,
    input  logic                     wb_ack,
    output logic                     proto_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_RESPOND = 2'd2,
        S_WB      = 2'd3
    } fsm_t;

    fsm_t                  state_q;
    logic [2:0]            op_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [INDEX_BITS-1:0] index_q;
    logic                  rd_en_q;
    logic                  wb_req_q;
    logic [WAY_BITS-1:0]   wb_way_q;

    logic                  w_hit;
    logic                  w_multi;
    logic [WAY_BITS-1:0]   w_hit_way;
    logic [2:0]            w_hit_state;
    snoop_resp_t           w_resp;
    logic                  w_respond;

    way_match #(
        .TAG_BITS (TAG_BITS),
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_way_match (
        .tag_i       (tag_q),
        .tags_i      (arr_tags),
        .states_i    (arr_states),
        .hit_o       (w_hit),
        .hit_way_o   (w_hit_way),
        .hit_state_o (w_hit_state),
        .multi_hit_o (w_multi)
    );

    assign w_resp = snoop_next(op_q, w_hit, w_hit_state);

    // Array data only arrives in RESPOND, so the result side is combinational;
    // gating with reset abandons a transaction caught mid-flight.
    assign w_respond = (state_q == S_RESPOND) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            tag_q    <= '0;
            index_q  <= '0;
            rd_en_q  <= 1'b0;
            wb_req_q <= 1'b0;
            wb_way_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (snoop_valid) begin
                        op_q    <= snoop_op;
                        tag_q   <= snoop_tag;
                        index_q <= snoop_index;
                        rd_en_q <= 1'b1;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (w_resp.wb) begin
                        wb_req_q <= 1'b1;
                        wb_way_q <= w_hit_way;
                        state_q  <= S_WB;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_WB: begin
                    if (wb_ack) begin
                        wb_req_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign snoop_ready        = (state_q == S_IDLE) && !reset;
    assign arr_rd_en          = rd_en_q;
    assign arr_index          = index_q;
    assign snoop_result_valid = w_respond;
    assign snoop_result       = w_respond ? w_resp.result : c_RES_NOHIT;
    assign arr_wr_en          = w_respond && w_resp.write;
    assign arr_wr_way         = w_respond ? w_hit_way : '0;
    assign arr_wr_state       = w_respond ? w_resp.next_state : 3'd0;
    assign proto_err          = w_respond && (w_resp.err || w_multi);
    assign wb_req             = wb_req_q;
    assign wb_tag             = tag_q;
    assign wb_index           = index_q;
    assign wb_way             = wb_way_q;

endmodule
`default_nettype wire

// File: doc/snoop_responder.md
# snoop_responder

Bus-side MESIF snoop responder for the L2 cache model. It accepts snooped bus operations (READ, WRITE, INVALIDATE, RFO) issued by other caches and looks up the addressed set in the tag/state array. It drives the snoop result (HIT/HITM/NOHIT) and writes the next MESIF state back into the array. For modified lines it requests a writeback. It is the counterpart of the processor-side MESIF line FSM, which initiates bus operations and consumes snoop results.

## Interface
Parameters:
- tag_bits, 12, tag width
- index_bits, 14, set index width
- ways, 8, associativity; must be a power of 2
- way_bits, 3, log2(ways)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- snoop_valid  in  1  snooped operation present
- snoop_ready  out  1  responder can accept (IDLE only)
- snoop_op  in  3  READ=1, WRITE=2, INVALIDATE=3, RFO=4
- snoop_tag  in  tag_bits  snooped tag
- snoop_index  in  index_bits  snooped set
- arr_rd_en  out  1  array read strobe
- arr_index  out  index_bits  array set address (read and write)
- arr_tags  in  ways*tag_bits  packed tags, way 0 in LSBs, valid 1 cycle after arr_rd_en
- arr_states  in  ways*3  packed MESIF states, same timing
- arr_wr_en  out  1  state write strobe
- arr_wr_way  out  way_bits  way written
- arr_wr_state  out  3  new state
- snoop_result_valid  out  1  one-cycle result pulse
- snoop_result  out  2  HIT=0, HITM=1, NOHIT=3
- wb_req  out  1  writeback request, held until wb_ack
- wb_tag / wb_index / wb_way  out  tag_bits / index_bits / way_bits  writeback line identity
- wb_ack  in  1  writeback accepted
- proto_err  out  1  one-cycle protocol-violation pulse

## Operation
- State encoding: M=0, E=1, S=2, I=3, F=4. A way hits when its tag matches and its state != I. On multiple hits the lowest way is used and proto_err pulses.
- FSM states: IDLE, LOOKUP, RESPOND, WB.
- IDLE: snoop_ready=1. On snoop_valid, register op, tag and index, then go to LOOKUP.
- LOOKUP: arr_rd_en=1, arr_index=captured index. Go to RESPOND.
- RESPOND: compare tags, then drive snoop_result_valid=1, and drive arr_wr_en=1 only when the state changes:
  - READ: M gives HITM, next S, go to WB. E and F give HIT, next S. S gives HIT, no change. Miss gives NOHIT.
  - RFO: M gives HITM, next I, go to WB. E, S and F give HIT, next I. Miss gives NOHIT.
  - INVALIDATE: S and F give HIT, next I. M and E give NOHIT, next I, proto_err. Miss gives NOHIT.
  - WRITE: miss gives NOHIT. Any hit gives NOHIT, no state change, proto_err.
  - Illegal op code (0, 5-7): NOHIT, no write, proto_err.
- After RESPOND, go to WB if HITM, otherwise IDLE.
- WB: wb_req=1 with the captured tag, index and hit way. On wb_ack go to IDLE. wb_ack outside WB is ignored.
- The cache controller stalls CPU-side array access while snoop_ready=0.

## Timing
- Snoop accepted at cycle T: arr_rd_en at T+1, result and array write at T+2, snoop_ready high again at T+3 when no writeback is needed.
- On HITM, wb_req is high from T+3. If wb_ack arrives in cycle W, wb_req is low and the FSM is in IDLE at W+1. The minimum is T+4.
- Peak throughput: one snoop per 3 cycles.
- The snoop source holds snoop_valid and its fields stable until snoop_ready. The responder captures them at acceptance, so later changes are ignored.
- Reset values:
  - FSM in IDLE.
  - snoop_ready=0 while reset is asserted, and 1 in the first cycle after release.
  - arr_rd_en, arr_wr_en, snoop_result_valid, wb_req and proto_err are 0.
  - snoop_result=NOHIT.
  - All address and way outputs are 0.
- Reset mid-operation: the transaction is abandoned, with no array write and no result. wb_req drops at the next edge.
- Outside RESPOND, snoop_result is held at NOHIT.

## Structure
- mesif_pkg holds the state encodings, bus op codes, snoop result codes and a next-state/result function, shared with the processor-side MESIF FSM.
- Sub-module way_match: combinational tag compare across the ways plus a lowest-index priority encoder. Outputs are hit, hit_way, hit_state and multi_hit.

## Test plan
- Reset, then READ to a set holding way 2 in M with a matching tag -> HITM at T+2, arr_wr_way=2, arr_wr_state=S, wb_req from T+3. wb_ack at T+5 -> snoop_ready at T+6.
- RFO hitting way 0 in F -> HIT, arr_wr_state=I, no wb_req, snoop_ready at T+3.
- READ to a set where all ways are I, or no tag matches -> NOHIT, no arr_wr_en, no wb_req.
- Back-to-back snoops with snoop_valid held continuously -> accepted at T, T+3 and T+6, results at T+2, T+5 and T+8.
- INVALIDATE hitting a line in E, and WRITE hitting a line in S -> proto_err pulses. E is written to I; S is left unchanged. Both return NOHIT.
- Reset asserted during WB with wb_ack never given -> wb_req=0 on the next edge, snoop_ready=1 after release, no further array writes.
